lm_sm_sequencer: RTL and testbench

Multi-cycle sequencer for the load-multiple / store-multiple instructions. Walks an 8-bit register mask from R0 to R7 and emits one register index per transfer. That index drives the select input of the 16-bit 8-to-1 register read mux for SM, and the register-file write address for LM. It also generates the matching incrementing memory address and strobes, and sits between the control FSM and the register read mux / memory interface.

---
 rtl/lm_sm_pkg.sv | 14 +
 rtl/lm_sm_sequencer_if.sv | 33 +++
 rtl/lm_sm_sequencer_pri_enc8.sv | 19 +
 rtl/lm_sm_sequencer.sv | 120 ++++++++++++
 tb/tb_lm_sm_sequencer.sv | 115 +++++++++++
 5 files changed

// File: rtl/lm_sm_pkg.sv
// rtl/lm_sm_pkg.sv - shared widths and state encoding for the LM/SM sequencer
package lm_sm_pkg;

    localparam int ADDR_W = 16;
    localparam int MASK_W = 8;
    localparam int SEL_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/lm_sm_sequencer_if.sv
// rtl/lm_sm_sequencer_if.sv - control and memory-side signal bundle of the LM/SM sequencer
interface lm_sm_sequencer_if
    import lm_sm_pkg::*;
#(
    parameter int A_W = ADDR_W,
    parameter int M_W = MASK_W,
    parameter int S_W = SEL_W
);
    logic           start;
    logic           is_store;
    logic [M_W-1:0] mask;
    logic [A_W-1:0] base_addr;
    logic           mem_ready;
    logic [S_W-1:0] reg_sel;
    logic [A_W-1:0] mem_addr;
    logic           xfer_valid;
    logic           mem_we;
    logic           rf_we;
    logic           busy;
    logic           done;
    logic [3:0]     xfer_count;

    // master: control FSM + memory side; slave: the sequencer
    modport master (
        output start, is_store, mask, base_addr, mem_ready,
        input  reg_sel, mem_addr, xfer_valid, mem_we, rf_we, busy, done, xfer_count
    );

    modport slave (
        input  start, is_store, mask, base_addr, mem_ready,
        output reg_sel, mem_addr, xfer_valid, mem_we, rf_we, busy, done, xfer_count
    );
endinterface

// File: rtl/lm_sm_sequencer_pri_enc8.sv
// rtl/lm_sm_sequencer_pri_enc8.sv - lowest-set-bit encoder, 8 bits to 3-bit index plus any flag
module pri_enc8 (
    input  logic [7:0] in,
    output logic [2:0] idx,
    output logic       any
);

    // scan downward so the lowest set bit is the last one written
    always_comb begin
        idx = 3'd0;
        any = |in;
        for (int i = 7; i >= 0; i--) begin
            if (in[i]) begin
                idx = i[2:0];
            end
        end
    end

endmodule

// File: rtl/lm_sm_sequencer.sv
// rtl/lm_sm_sequencer.sv - walks an LM/SM register mask, one register index and address per transfer
module lm_sm_sequencer
    import lm_sm_pkg::*;
#(
    parameter int A_W = ADDR_W,
    parameter int M_W = MASK_W,
    parameter int S_W = SEL_W
) (
    input  logic                 clk,
    input  logic                 reset,
    lm_sm_sequencer_if.slave     bus
);

    state_e         state_q, state_d;
    logic [M_W-1:0] pend_q, pend_d;
    logic [A_W-1:0] addr_q, addr_d;
    logic           store_q, store_d;
    logic [3:0]     count_q, count_d;

    logic [S_W-1:0] sel;
    logic           any;
    logic           last;
    logic [M_W-1:0] sel_bit;

    logic [S_W-1:0] reg_sel;
    logic [A_W-1:0] mem_addr;
    logic           xfer_valid;
    logic           mem_we;
    logic           rf_we;
    logic           busy;
    logic           done;

    pri_enc8 u_enc (
        .in  (pend_q),
        .idx (sel),
        .any (any)
    );

    // x & (x-1) drops the lowest set bit; zero means this transfer is the final one
    assign last    = ~|(pend_q & (pend_q - M_W'(1)));
    assign sel_bit = M_W'(1) << sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            addr_q  <= '0;
            store_q <= 1'b0;
            count_q <= 4'd0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        addr_d     = addr_q;
        store_d    = store_q;
        count_d    = count_q;
        reg_sel    = '0;
        mem_addr   = '0;
        xfer_valid = 1'b0;
        mem_we     = 1'b0;
        rf_we      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    pend_d  = bus.mask;
                    addr_d  = bus.base_addr;
                    store_d = bus.is_store;
                    count_d = 4'd0;
                    state_d = (|bus.mask) ? ST_XFER : ST_DONE;
                end
            end
            ST_XFER: begin
                busy       = 1'b1;
                xfer_valid = any;
                reg_sel    = sel;
                mem_addr   = addr_q;
                mem_we     = any & store_q;
                rf_we      = any & bus.mem_ready & ~store_q;
                // a stall simply leaves every register untouched
                if (bus.mem_ready) begin
                    pend_d  = pend_q & ~sel_bit;
                    addr_d  = addr_q + A_W'(1);
                    count_d = count_q + 4'd1;
                    if (last) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.reg_sel    = reg_sel;
    assign bus.mem_addr   = mem_addr;
    assign bus.xfer_valid = xfer_valid;
    assign bus.mem_we     = mem_we;
    assign bus.rf_we      = rf_we;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.xfer_count = count_q;

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// tb/tb_lm_sm_sequencer.sv - directed-vector bench for lm_sm_sequencer
module tb_lm_sm_sequencer;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    lm_sm_sequencer_if bus ();

    lm_sm_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [27:0] got, input logic [27:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got xv/we/rfwe/busy/done=%b sel=%0d addr=%h cnt=%0d, expected %b sel=%0d addr=%h cnt=%0d",
                     tag, got[27:23], got[22:20], got[19:4], got[3:0],
                     exp[27:23], exp[22:20], exp[19:4], exp[3:0]);
        end
    endtask

    // xv, mem_we, rf_we, busy, done, reg_sel, mem_addr, xfer_count
    task automatic v(input string tag, input logic xv, input logic we, input logic rwe,
                     input logic bsy, input logic dn, input logic [2:0] sel,
                     input logic [15:0] a, input logic [3:0] cnt);
        #1;
        chk(tag, {bus.xfer_valid, bus.mem_we, bus.rf_we, bus.busy, bus.done,
                  bus.reg_sel, bus.mem_addr, bus.xfer_count},
                 {xv, we, rwe, bsy, dn, sel, a, cnt});
    endtask

    task automatic drv(input logic s, input logic st, input logic [7:0] m,
                       input logic [15:0] b, input logic r);
        bus.start     = s;
        bus.is_store  = st;
        bus.mask      = m;
        bus.base_addr = b;
        bus.mem_ready = r;
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        drv(0, 0, 8'h00, 16'h0000, 0);
        nxt(); v("rst_a", 0,0,0,0,0, 0, 16'h0000, 0);
        nxt(); v("rst_b", 0,0,0,0,0, 0, 16'h0000, 0);
        reset = 1'b0;

        // SM, mask A5, no stalls
        nxt(); drv(1, 1, 8'hA5, 16'h0040, 1); v("sm_idle", 0,0,0,0,0, 0, 16'h0000, 0);
        nxt(); bus.start = 0; v("sm_x0", 1,1,0,1,0, 0, 16'h0040, 0);
        nxt(); v("sm_x2", 1,1,0,1,0, 2, 16'h0041, 1);
        nxt(); v("sm_x5", 1,1,0,1,0, 5, 16'h0042, 2);
        nxt(); v("sm_x7", 1,1,0,1,0, 7, 16'h0043, 3);
        nxt(); v("sm_done", 0,0,0,1,1, 0, 16'h0000, 4);
        nxt(); v("sm_after", 0,0,0,0,0, 0, 16'h0000, 4);

        // LM, mask 81, 3-cycle stall on the first transfer
        nxt(); drv(1, 0, 8'h81, 16'h1000, 0); v("lm_idle", 0,0,0,0,0, 0, 16'h0000, 4);
        nxt(); bus.start = 0; v("lm_st1", 1,0,0,1,0, 0, 16'h1000, 0);
        nxt(); v("lm_st2", 1,0,0,1,0, 0, 16'h1000, 0);
        nxt(); v("lm_st3", 1,0,0,1,0, 0, 16'h1000, 0);
        nxt(); bus.mem_ready = 1; v("lm_r0", 1,0,1,1,0, 0, 16'h1000, 0);
        nxt(); v("lm_r7", 1,0,1,1,0, 7, 16'h1001, 1);
        nxt(); v("lm_done", 0,0,0,1,1, 0, 16'h0000, 2);
        nxt(); v("lm_after", 0,0,0,0,0, 0, 16'h0000, 2);

        // empty mask
        nxt(); drv(1, 1, 8'h00, 16'h2222, 1); v("z_idle", 0,0,0,0,0, 0, 16'h0000, 2);
        nxt(); bus.start = 0; v("z_done", 0,0,0,1,1, 0, 16'h0000, 0);
        nxt(); v("z_after", 0,0,0,0,0, 0, 16'h0000, 0);

        // address wrap FFFF -> 0000
        nxt(); drv(1, 0, 8'hC0, 16'hFFFF, 1); v("w_idle", 0,0,0,0,0, 0, 16'h0000, 0);
        nxt(); bus.start = 0; v("w_x6", 1,0,1,1,0, 6, 16'hFFFF, 0);
        nxt(); v("w_x7", 1,0,1,1,0, 7, 16'h0000, 1);
        nxt(); v("w_done", 0,0,0,1,1, 0, 16'h0000, 2);
        nxt(); v("w_after", 0,0,0,0,0, 0, 16'h0000, 2);

        // starts while busy and on DONE are ignored; next-cycle start is taken
        nxt(); drv(1, 1, 8'h03, 16'h0020, 1); v("b_idle", 0,0,0,0,0, 0, 16'h0000, 2);
        nxt(); drv(1, 0, 8'hFF, 16'h0500, 1); v("b_x0", 1,1,0,1,0, 0, 16'h0020, 0);
        nxt(); bus.start = 0; v("b_x1", 1,1,0,1,0, 1, 16'h0021, 1);
        nxt(); drv(1, 1, 8'h10, 16'h0300, 1); v("b_done", 0,0,0,1,1, 0, 16'h0000, 2);
        nxt(); v("b_idle2", 0,0,0,0,0, 0, 16'h0000, 2);
        nxt(); bus.start = 0; v("b_x4", 1,1,0,1,0, 4, 16'h0300, 0);
        nxt(); v("b_done2", 0,0,0,1,1, 0, 16'h0000, 1);
        nxt(); v("b_after", 0,0,0,0,0, 0, 16'h0000, 1);

        // reset held 2 cycles in the middle of an FF store sequence
        nxt(); drv(1, 1, 8'hFF, 16'h0010, 1); v("r_idle", 0,0,0,0,0, 0, 16'h0000, 1);
        nxt(); bus.start = 0; v("r_x0", 1,1,0,1,0, 0, 16'h0010, 0);
        nxt(); v("r_x1", 1,1,0,1,0, 1, 16'h0011, 1);
        nxt(); reset = 1'b1; v("r_x2", 1,1,0,1,0, 2, 16'h0012, 2);
        nxt(); v("r_hold1", 0,0,0,0,0, 0, 16'h0000, 0);
        nxt(); v("r_hold2", 0,0,0,0,0, 0, 16'h0000, 0);
        reset = 1'b0;
        nxt(); v("r_post1", 0,0,0,0,0, 0, 16'h0000, 0);
        nxt(); v("r_post2", 0,0,0,0,0, 0, 16'h0000, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
